// File: rtl/adc_clk_ctrl.sv
// ADC LVDS clocking bring-up: MMCM reset/lock/settle sequencing,
// frame alignment via bitslip, and lock/alignment supervision.
module adc_clk_ctrl #(
    parameter int unsigned       RST_CYCLES    = 16,
    parameter int unsigned       LOCK_TIMEOUT  = 65535,
    parameter int unsigned       SETTLE_CYCLES = 255,
    parameter int unsigned       FRAME_W       = 8,
    parameter logic [FRAME_W-1:0] FRAME_PATTERN = 8'hF0,
    parameter int unsigned       MATCH_COUNT   = 4,
    parameter int unsigned       BITSLIP_GAP   = 4,
    parameter int unsigned       MAX_RETRIES   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mmcm_locked,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_word,
    output logic               mmcm_reset,
    output logic               bitslip,
    output logic               adc_ready,
    output logic               fail,
    output logic [2:0]         state,
    output logic [7:0]         relock_count,
    output logic [3:0]         slip_count
);

    localparam int unsigned TW_L = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned TW_S = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW_R = $clog2(RST_CYCLES + 1);
    localparam int unsigned TW_G = $clog2(BITSLIP_GAP + 1);
    localparam int unsigned TW_A = (TW_L > TW_S) ? TW_L : TW_S;
    localparam int unsigned TW_B = (TW_R > TW_G) ? TW_R : TW_G;
    localparam int unsigned TW   = (TW_A > TW_B) ? TW_A : TW_B;
    localparam int unsigned MW   = $clog2(MATCH_COUNT + 1);
    localparam int unsigned RW   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MMCM_RST  = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        ALIGN     = 3'd4,
        SLIP_WAIT = 3'd5,
        READY     = 3'd6,
        FAIL      = 3'd7
    } state_t;

    state_t          st;
    state_t          state_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;
    logic [RW-1:0]   retry_cnt;
    logic [RW-1:0]   retry_n;
    logic [RW-1:0]   retry_inc;
    logic [MW-1:0]   match_cnt;
    logic [MW-1:0]   match_n;
    logic [MW-1:0]   match_inc;
    logic [3:0]      slip_n;
    logic [7:0]      relock_n;
    logic            pulse_n;
    logic            do_retry;
    logic            word_ok;
    logic            lock_meta;
    logic            locked_s;

    assign state     = st;
    assign retry_inc = retry_cnt + RW'(1);
    assign match_inc = match_cnt + MW'(1);
    assign word_ok   = (frame_word == FRAME_PATTERN);

    // mmcm_locked comes from the MMCM, unrelated to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            locked_s  <= lock_meta;
        end
    end

    always_comb begin
        state_n  = st;
        timer_n  = timer;
        retry_n  = retry_cnt;
        match_n  = match_cnt;
        slip_n   = slip_count;
        relock_n = relock_count;
        pulse_n  = 1'b0;
        do_retry = 1'b0;
        unique case (st)
            IDLE: begin
                if (enable) begin
                    state_n = MMCM_RST;
                    retry_n = '0;
                    timer_n = '0;
                end
            end
            MMCM_RST: begin
                if (timer == TW'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = SETTLE;
                    timer_n = '0;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    do_retry = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    do_retry = 1'b1;
                end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
                    state_n = ALIGN;
                    slip_n  = '0;
                    match_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ALIGN: begin
                // lock loss outranks whatever frame arrives this cycle
                if (!locked_s) begin
                    do_retry = 1'b1;
                end else if (frame_valid) begin
                    if (word_ok) begin
                        match_n = match_inc;
                        if (match_inc == MW'(MATCH_COUNT)) begin
                            state_n = READY;
                        end
                    end else begin
                        match_n = '0;
                        if (slip_count == 4'(FRAME_W - 1)) begin
                            do_retry = 1'b1;
                        end else begin
                            pulse_n = 1'b1;
                            slip_n  = slip_count + 4'd1;
                            state_n = SLIP_WAIT;
                            timer_n = '0;
                        end
                    end
                end
            end
            SLIP_WAIT: begin
                if (!locked_s) begin
                    do_retry = 1'b1;
                end else if (timer == TW'(BITSLIP_GAP - 1)) begin
                    state_n = ALIGN;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            READY: begin
                if (!locked_s) begin
                    state_n = MMCM_RST;
                    timer_n = '0;
                    retry_n = '0;
                    if (relock_count != 8'hFF) begin
                        relock_n = relock_count + 8'd1;
                    end
                end else if (frame_valid && !word_ok) begin
                    state_n = ALIGN;
                    slip_n  = '0;
                    match_n = '0;
                end
            end
            FAIL: begin
                state_n = FAIL;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (do_retry) begin
            retry_n = retry_inc;
            timer_n = '0;
            state_n = (retry_inc == RW'(MAX_RETRIES)) ? FAIL : MMCM_RST;
        end
        // dropping enable wins over everything, including a pending slip
        if (!enable) begin
            state_n = IDLE;
            timer_n = '0;
            pulse_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            timer        <= '0;
            retry_cnt    <= '0;
            match_cnt    <= '0;
            slip_count   <= '0;
            relock_count <= '0;
            bitslip      <= 1'b0;
            mmcm_reset   <= 1'b1;
            adc_ready    <= 1'b0;
            fail         <= 1'b0;
        end else begin
            st           <= state_n;
            timer        <= timer_n;
            retry_cnt    <= retry_n;
            match_cnt    <= match_n;
            slip_count   <= slip_n;
            relock_count <= relock_n;
            bitslip      <= pulse_n;
            mmcm_reset   <= (state_n == IDLE) || (state_n == MMCM_RST) ||
                            (state_n == FAIL);
            adc_ready    <= (state_n == READY);
            fail         <= (state_n == FAIL);
        end
    end

endmodule
